// File: rtl/cim_tile_sequencer.sv
// Hardware initiator for a CIM macro: loads a weight tile from RAM, streams input vectors
// through the macro and drains the output registers back to RAM, one job per start pulse.
module cim_tile_sequencer #(
  parameter int unsigned N_ROWS = 32,
  parameter int unsigned N_OUT  = 16
) (
  input  logic        CLK,
  input  logic        RESN,
  input  logic        start,
  input  logic        accumulate,
  input  logic [31:0] w_base,
  input  logic [31:0] x_base,
  input  logic [31:0] y_base,
  input  logic [15:0] n_vec,
  output logic        busy,
  output logic        done,
  output logic [31:0] mem_addr,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        write,
  output logic        cim,
  output logic        partial_sum,
  output logic        reset_output,
  output logic [3:0]  output_reg,
  output logic [31:0] address,
  output logic [31:0] input_data,
  input  logic [31:0] cim_output
);

  localparam int unsigned CntMax = (N_ROWS > N_OUT) ? N_ROWS : N_OUT;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  localparam logic [CntW-1:0] RowsLast = CntW'(N_ROWS);
  localparam logic [CntW-1:0] OutLast  = CntW'(N_OUT);
  localparam logic [CntW-1:0] CntZero  = '0;
  localparam logic [CntW-1:0] CntOne   = CntW'(1);
  localparam logic [31:0]     NOut32   = 32'(N_OUT);

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StLoadW   = 3'd1;
  localparam logic [2:0] StClr     = 3'd2;
  localparam logic [2:0] StFetch   = 3'd3;
  localparam logic [2:0] StCompute = 3'd4;
  localparam logic [2:0] StDrain   = 3'd5;
  localparam logic [2:0] StDone    = 3'd6;

  logic [2:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [15:0]     vec_q, vec_d;
  logic            acc_q;
  logic [31:0]     w_base_q, x_base_q, y_base_q;
  logic [15:0]     n_vec_q;

  logic            launch;
  logic            vec_last;
  logic [CntW-1:0] cnt_m1;
  logic [31:0]     blk;

  assign launch   = (state_q == StIdle) && start;
  assign vec_last = (vec_q == n_vec_q - 16'd1);
  assign cnt_m1   = cnt_q - CntOne;
  assign blk      = acc_q ? 32'd0 : 32'(vec_q);

  always_ff @(posedge CLK or negedge RESN) begin
    if (!RESN) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      vec_q    <= '0;
      acc_q    <= 1'b0;
      w_base_q <= '0;
      x_base_q <= '0;
      y_base_q <= '0;
      n_vec_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vec_q   <= vec_d;
      if (launch) begin
        acc_q    <= accumulate;
        w_base_q <= w_base;
        x_base_q <= x_base;
        y_base_q <= y_base;
        n_vec_q  <= n_vec;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    vec_d   = vec_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StLoadW;
          cnt_d   = '0;
        end
      end
      StLoadW: begin
        if (cnt_q == RowsLast) begin
          state_d = StClr;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      StClr: begin
        vec_d   = '0;
        state_d = (n_vec_q == 16'd0) ? StDone : StFetch;
      end
      StFetch: state_d = StCompute;
      StCompute: begin
        cnt_d = '0;
        // Accumulate mode chains straight into the next fetch; only the last vector drains.
        if (acc_q && !vec_last) begin
          state_d = StFetch;
          vec_d   = vec_q + 16'd1;
        end else begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (cnt_q == OutLast) begin
          cnt_d = '0;
          if (acc_q || vec_last) begin
            state_d = StDone;
          end else begin
            state_d = StFetch;
            vec_d   = vec_q + 16'd1;
          end
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy         = (state_q != StIdle) && (state_q != StDone);
    done         = (state_q == StDone);
    mem_addr     = '0;
    mem_rd       = 1'b0;
    mem_wr       = 1'b0;
    mem_wdata    = '0;
    write        = 1'b0;
    cim          = 1'b0;
    partial_sum  = 1'b0;
    reset_output = 1'b0;
    output_reg   = '0;
    address      = '0;
    input_data   = '0;
    unique case (state_q)
      StLoadW: begin
        // Read of row i overlaps the CIM write of row i-1.
        if (cnt_q != RowsLast) begin
          mem_rd   = 1'b1;
          mem_addr = w_base_q + (32'(cnt_q) << 2);
        end
        if (cnt_q != CntZero) begin
          write      = 1'b1;
          address    = 32'(cnt_m1);
          input_data = mem_rdata;
        end
      end
      StClr: reset_output = 1'b1;
      StFetch: begin
        mem_rd   = 1'b1;
        mem_addr = x_base_q + (32'(vec_q) << 2);
      end
      StCompute: begin
        cim         = 1'b1;
        input_data  = mem_rdata;
        partial_sum = acc_q;
      end
      StDrain: begin
        if (cnt_q != OutLast) begin
          output_reg = 4'(cnt_q);
        end
        if (cnt_q != CntZero) begin
          mem_wr    = 1'b1;
          mem_wdata = cim_output;
          mem_addr  = y_base_q + ((blk * NOut32 + 32'(cnt_m1)) << 2);
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cim_tile_sequencer.sv
// Self-checking bench for cim_tile_sequencer: RAM and CIM macro models plus a job-level
// reference that predicts drained results, write addresses and busy length.
module tb_cim_tile_sequencer;

  localparam int NR = 32;
  localparam int NO = 16;

  logic        CLK = 1'b0;
  logic        RESN = 1'b0;
  logic        start = 1'b0;
  logic        accumulate = 1'b0;
  logic [31:0] w_base = '0, x_base = '0, y_base = '0;
  logic [15:0] n_vec = '0;
  logic        busy, done, mem_rd, mem_wr, write, cim, partial_sum, reset_output;
  logic [31:0] mem_addr, mem_wdata, address, input_data;
  logic [3:0]  output_reg;
  logic [31:0] mem_rdata = '0;
  logic [31:0] cim_output = '0;

  always #5 CLK = ~CLK;

  cim_tile_sequencer #(.N_ROWS(NR), .N_OUT(NO)) dut (
    .CLK(CLK), .RESN(RESN), .start(start), .accumulate(accumulate),
    .w_base(w_base), .x_base(x_base), .y_base(y_base), .n_vec(n_vec),
    .busy(busy), .done(done), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .write(write), .cim(cim),
    .partial_sum(partial_sum), .reset_output(reset_output), .output_reg(output_reg),
    .address(address), .input_data(input_data), .cim_output(cim_output)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // RAM: explicit entries override a deterministic hash of the address.
  logic [31:0] ram [logic [31:0]];
  logic [31:0] seed = 32'h5EED_0001;

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    if (ram.exists(a)) return ram[a];
    return (a ^ seed) * 32'h9E37_79B1 + 32'h1234_5677;
  endfunction

  // Output column j of the macro for one input vector.
  function automatic logic [31:0] cim_col(input logic [31:0] w [NR], input logic [31:0] x,
                                          input int j);
    logic [31:0] s = '0;
    for (int r = 0; r < NR; r++) if (w[r][j]) s += x ^ (32'(r) * 32'h0101_0101);
    return s;
  endfunction

  logic [31:0] cw [NR];
  logic [31:0] co [NO];
  logic        rd_pend = 1'b0;
  logic [31:0] rd_addr_c = '0;
  logic [3:0]  oreg_c = '0;

  int busy_cnt, done_cnt, excl, rd_cnt;
  logic [31:0] wa_q[$], wd_q[$], la_q[$], ld_q[$];
  logic        ps_q[$];
  logic [31:0] exp_wa[$], exp_wd[$];
  int          exp_busy;

  // Monitor and device models sample mid-cycle; device responses land on the next edge.
  always @(negedge CLK) begin
    if (busy) busy_cnt++;
    if (done) done_cnt++;
    if (mem_rd && mem_wr) excl++;
    if (int'(write) + int'(cim) + int'(reset_output) > 1) excl++;
    if (mem_rd) rd_cnt++;
    if (mem_wr) begin wa_q.push_back(mem_addr); wd_q.push_back(mem_wdata); end
    if (write) begin la_q.push_back(address); ld_q.push_back(input_data); end
    if (cim) ps_q.push_back(partial_sum);
    if (write) cw[address % NR] = input_data;
    if (reset_output) for (int j = 0; j < NO; j++) co[j] = '0;
    if (cim) for (int j = 0; j < NO; j++) co[j] = (partial_sum ? co[j] : 32'd0) + cim_col(cw, input_data, j);
    rd_pend   = mem_rd;
    rd_addr_c = mem_addr;
    oreg_c    = output_reg;
  end

  always @(posedge CLK) begin
    mem_rdata  <= rd_pend ? rd_word(rd_addr_c) : 32'h0BAD_F00D;
    cim_output <= co[oreg_c];
  end

  task automatic build_expected(input logic acc, input logic [31:0] wb, xb, yb,
                                input logic [15:0] nv);
    logic [31:0] w [NR];
    logic [31:0] o [NO];
    logic [31:0] x;
    exp_wa.delete(); exp_wd.delete();
    for (int r = 0; r < NR; r++) w[r] = rd_word(wb + 32'(4 * r));
    for (int j = 0; j < NO; j++) o[j] = '0;
    for (int v = 0; v < int'(nv); v++) begin
      x = rd_word(xb + 32'(4 * v));
      for (int j = 0; j < NO; j++) o[j] = (acc ? o[j] : 32'd0) + cim_col(w, x, j);
      if (!acc) for (int k = 0; k < NO; k++) begin
        exp_wa.push_back(yb + 32'(4 * (v * NO + k))); exp_wd.push_back(o[k]);
      end
    end
    if (acc && nv != 0) for (int k = 0; k < NO; k++) begin
      exp_wa.push_back(yb + 32'(4 * k)); exp_wd.push_back(o[k]);
    end
    if (nv == 0) exp_busy = NR + 2;
    else if (acc) exp_busy = NR + 2 + 2 * int'(nv) + NO + 1;
    else exp_busy = NR + 2 + int'(nv) * (NO + 3);
  endtask

  function automatic int first_diff();
    int n = (wa_q.size() < exp_wa.size()) ? wa_q.size() : exp_wa.size();
    for (int i = 0; i < n; i++) if (wa_q[i] !== exp_wa[i] || wd_q[i] !== exp_wd[i]) return i;
    if (wa_q.size() != exp_wa.size()) return n;
    return -1;
  endfunction

  task automatic launch(input logic acc, input logic [31:0] wb, xb, yb, input logic [15:0] nv);
    @(negedge CLK); #1;
    busy_cnt = 0; done_cnt = 0; excl = 0; rd_cnt = 0;
    wa_q.delete(); wd_q.delete(); la_q.delete(); ld_q.delete(); ps_q.delete();
    accumulate = acc; w_base = wb; x_base = xb; y_base = yb; n_vec = nv; start = 1'b1;
    @(negedge CLK); #1;
    start = 1'b0;
    accumulate = ~acc; w_base = $urandom; x_base = $urandom; y_base = $urandom; n_vec = 16'($urandom);
  endtask

  task automatic wait_done(output bit ok);
    for (int i = 0; i < 3000 && done_cnt == 0; i++) begin @(negedge CLK); #1; end
    ok = (done_cnt != 0);
    repeat (4) begin @(negedge CLK); #1; end
  endtask

  function automatic logic [31:0] rnd_addr();
    return {$urandom} & 32'hFFFF_FFFC;
  endfunction

  task automatic test_reset();
    RESN = 1'b0;
    repeat (3) @(negedge CLK);
    n_cmp++;
    if ({busy, done, mem_addr, mem_rd, mem_wr, mem_wdata, write, cim, partial_sum, reset_output,
         output_reg, address, input_data} !== '0) begin
      n_bad++; $display("FAIL reset_outputs: got busy=%b done=%b mem_addr=%h want all zero",
                        busy, done, mem_addr);
    end
    #1 RESN = 1'b1;
  endtask

  task automatic test_weight_load();
    bit ok;
    int bad = 0;
    for (int i = 0; i < NR; i++) ram[32'h100 + 32'(4 * i)] = 32'hA000_0000 + 32'(i);
    launch(1'b0, 32'h100, 32'h200, 32'h300, 16'd0);
    wait_done(ok);
    n_cmp++; if (!ok || done_cnt != 1) begin n_bad++; $display("FAIL wl_done: got %0d want 1", done_cnt); end
    n_cmp++; if (busy_cnt != 34) begin n_bad++; $display("FAIL wl_busy: got %0d want 34", busy_cnt); end
    n_cmp++; if (la_q.size() != NR) begin n_bad++; $display("FAIL wl_writes: got %0d want %0d", la_q.size(), NR); end
    for (int i = 0; i < la_q.size() && i < NR; i++)
      if (la_q[i] !== 32'(i) || ld_q[i] !== 32'hA000_0000 + 32'(i)) bad++;
    n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL wl_rows: got %0d wrong rows want 0", bad); end
    n_cmp++; if (wa_q.size() != 0) begin n_bad++; $display("FAIL wl_memwr: got %0d want 0", wa_q.size()); end
  endtask

  task automatic test_per_vector();
    bit ok;
    int d;
    build_expected(1'b0, 32'h100, 32'h200, 32'd43776, 16'd2);
    launch(1'b0, 32'h100, 32'h200, 32'd43776, 16'd2);
    wait_done(ok);
    n_cmp++; if (!ok || done_cnt != 1) begin n_bad++; $display("FAIL pv_done: got %0d want 1", done_cnt); end
    n_cmp++; if (busy_cnt != exp_busy) begin n_bad++; $display("FAIL pv_busy: got %0d want %0d", busy_cnt, exp_busy); end
    d = first_diff();
    n_cmp++; if (d != -1) begin n_bad++; $display("FAIL pv_writes: differ at %0d, got %0d writes want %0d", d, wa_q.size(), exp_wa.size()); end
    n_cmp++; if (wa_q.size() > 0 && wa_q[wa_q.size()-1] !== 32'd43900) begin
      n_bad++; $display("FAIL pv_last_addr: got %0d want 43900", wa_q[wa_q.size()-1]); end
    n_cmp++; if (ps_q.size() != 2 || ps_q[0] !== 1'b0 || ps_q[1] !== 1'b0) begin
      n_bad++; $display("FAIL pv_psum: got %0d pulses want 2 with partial_sum=0", ps_q.size()); end
    n_cmp++; if (excl != 0) begin n_bad++; $display("FAIL pv_excl: got %0d want 0", excl); end
  endtask

  task automatic test_accumulate();
    bit ok;
    int d;
    logic [31:0] wb = rnd_addr(), xb = rnd_addr(), yb = rnd_addr();
    build_expected(1'b1, wb, xb, yb, 16'd3);
    launch(1'b1, wb, xb, yb, 16'd3);
    wait_done(ok);
    n_cmp++; if (!ok || done_cnt != 1) begin n_bad++; $display("FAIL acc_done: got %0d want 1", done_cnt); end
    n_cmp++; if (busy_cnt != 57) begin n_bad++; $display("FAIL acc_busy: got %0d want 57", busy_cnt); end
    n_cmp++; if (ps_q.size() != 3 || ps_q.sum() with (int'(item)) != 3) begin
      n_bad++; $display("FAIL acc_psum: got %0d pulses want 3 with partial_sum=1", ps_q.size()); end
    d = first_diff();
    n_cmp++; if (d != -1) begin n_bad++; $display("FAIL acc_writes: differ at %0d, got %0d writes want %0d", d, wa_q.size(), exp_wa.size()); end
  endtask

  task automatic test_restart_ignored();
    bit ok;
    int d;
    logic [31:0] wb = rnd_addr(), xb = rnd_addr(), yb = rnd_addr();
    build_expected(1'b0, wb, xb, yb, 16'd2);
    launch(1'b0, wb, xb, yb, 16'd2);
    repeat (5) begin @(negedge CLK); #1; end
    accumulate = 1'b1; w_base = rnd_addr(); x_base = rnd_addr(); y_base = rnd_addr();
    n_vec = 16'd5; start = 1'b1;
    @(negedge CLK); #1;
    start = 1'b0;
    wait_done(ok);
    n_cmp++; if (!ok || done_cnt != 1) begin n_bad++; $display("FAIL rs_done: got %0d want 1", done_cnt); end
    n_cmp++; if (busy_cnt != 72) begin n_bad++; $display("FAIL rs_busy: got %0d want 72", busy_cnt); end
    d = first_diff();
    n_cmp++; if (d != -1) begin n_bad++; $display("FAIL rs_writes: differ at %0d, got %0d writes want %0d", d, wa_q.size(), exp_wa.size()); end
    n_cmp++; if (ps_q.size() != 2 || ps_q.sum() with (int'(item)) != 0) begin
      n_bad++; $display("FAIL rs_psum: got %0d pulses want 2 with partial_sum=0", ps_q.size()); end
  endtask

  task automatic test_reset_abort();
    bit ok;
    int d, nw, nr;
    logic [31:0] wb = rnd_addr(), xb = rnd_addr(), yb = rnd_addr();
    launch(1'b0, wb, xb, yb, 16'd2);
    for (int i = 0; i < 500 && wa_q.size() < 5; i++) begin @(negedge CLK); #1; end
    n_cmp++; if (wa_q.size() != 5) begin n_bad++; $display("FAIL ab_reach: got %0d writes want 5", wa_q.size()); end
    RESN = 1'b0;
    #1;
    n_cmp++;
    if ({busy, done, mem_addr, mem_rd, mem_wr, mem_wdata, write, cim, partial_sum, reset_output,
         output_reg, address, input_data} !== '0) begin
      n_bad++; $display("FAIL ab_outputs: got busy=%b mem_wr=%b mem_addr=%h want all zero",
                        busy, mem_wr, mem_addr);
    end
    nw = wa_q.size(); nr = rd_cnt; done_cnt = 0;
    repeat (5) begin @(negedge CLK); #1; end
    n_cmp++; if (done_cnt != 0 || wa_q.size() != nw || rd_cnt != nr) begin
      n_bad++; $display("FAIL ab_quiet: got done=%0d extra writes=%0d extra reads=%0d want 0",
                        done_cnt, wa_q.size() - nw, rd_cnt - nr); end
    RESN = 1'b1;
    build_expected(1'b1, xb, wb, yb, 16'd2);
    launch(1'b1, xb, wb, yb, 16'd2);
    wait_done(ok);
    n_cmp++; if (!ok || done_cnt != 1) begin n_bad++; $display("FAIL ab_rerun_done: got %0d want 1", done_cnt); end
    d = first_diff();
    n_cmp++; if (d != -1 || busy_cnt != exp_busy) begin
      n_bad++; $display("FAIL ab_rerun: diff at %0d, busy got %0d want %0d", d, busy_cnt, exp_busy); end
  endtask

  task automatic test_wrap();
    bit ok;
    int d;
    build_expected(1'b1, 32'h400, 32'h600, 32'hFFFF_FFF8, 16'd1);
    launch(1'b1, 32'h400, 32'h600, 32'hFFFF_FFF8, 16'd1);
    wait_done(ok);
    d = first_diff();
    n_cmp++; if (!ok || d != -1) begin n_bad++; $display("FAIL wrap_writes: diff at %0d, got %0d writes want %0d", d, wa_q.size(), exp_wa.size()); end
    n_cmp++; if (wa_q.size() < 4 || wa_q[1] !== 32'hFFFF_FFFC || wa_q[2] !== 32'h0 || wa_q[3] !== 32'h4) begin
      n_bad++; $display("FAIL wrap_addrs: got %0d writes, want FFFFFFFC,0,4 at entries 1..3", wa_q.size()); end
  endtask

  task automatic test_random();
    bit ok;
    int d;
    logic acc;
    logic [15:0] nv;
    logic [31:0] wb, xb, yb;
    for (int it = 0; it < 6; it++) begin
      acc = 1'($urandom); nv = 16'($urandom_range(0, 4));
      wb = rnd_addr(); xb = rnd_addr(); yb = rnd_addr();
      build_expected(acc, wb, xb, yb, nv);
      launch(acc, wb, xb, yb, nv);
      wait_done(ok);
      d = first_diff();
      n_cmp++; if (!ok || done_cnt != 1 || busy_cnt != exp_busy || d != -1 || excl != 0 || ps_q.size() != int'(nv)) begin
        n_bad++; $display("FAIL rand_job%0d: acc=%b nv=%0d done=%0d busy=%0d/%0d diff=%0d excl=%0d cim=%0d",
                          it, acc, nv, done_cnt, busy_cnt, exp_busy, d, excl, ps_q.size());
      end
    end
  endtask

  initial begin
    for (int r = 0; r < NR; r++) cw[r] = '0;
    for (int j = 0; j < NO; j++) co[j] = '0;
    test_reset();
    test_weight_load();
    test_per_vector();
    test_accumulate();
    test_restart_ignored();
    test_reset_abort();
    test_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at time limit");
    $fatal(1);
  end

endmodule

// File: doc/cim_tile_sequencer.md
# cim_tile_sequencer

Hardware initiator for the CIM macro command interface: it takes over the CPU's role of loading a weight tile, streaming input vectors, triggering in-memory compute and draining output registers back to data RAM. It sits between the data RAM port and the `Basic_GeMM_CIM` command/response pins. The CPU only programs base addresses and a vector count, pulses `start`, and then polls `busy` or waits for `done`.

## Interface
- `N_ROWS`, 32: weight rows per tile; CIM row addresses `0..N_ROWS-1`.
- `N_OUT`, 16: CIM output registers drained per result block; `output_reg` index `0..N_OUT-1`, `N_OUT` ≤ 16.
- `CLK`, input, 1: single clock; all logic on the rising edge.
- `RESN`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: one-cycle launch request; sampled only in IDLE.
- `accumulate`, input, 1: sampled with `start`. 0 = per-vector results; 1 = all vectors summed into one result block.
- `w_base`, `x_base`, `y_base`, input, 32 each: byte base addresses of weights, inputs and outputs; sampled with `start`.
- `n_vec`, input, 16: number of input vectors; sampled with `start`.
- `busy`, output, 1: high while a job runs.
- `done`, output, 1: one-cycle pulse when a job finishes.
- `mem_addr`, output, 32: RAM byte address.
- `mem_rd`, output, 1: RAM read strobe.
- `mem_wr`, output, 1: RAM write strobe.
- `mem_wdata`, output, 32: RAM write data.
- `mem_rdata`, input, 32: RAM read data; valid the cycle after `mem_rd`.
- `write`, output, 1: CIM weight-row write.
- `cim`, output, 1: CIM compute.
- `partial_sum`, output, 1: CIM accumulate (1) or overwrite (0).
- `reset_output`, output, 1: clear CIM output registers.
- `output_reg`, output, 4: CIM output register select.
- `address`, output, 32: CIM row address.
- `input_data`, output, 32: CIM weight row or input vector.
- `cim_output`, input, 32: CIM result; reflects `output_reg` one cycle after it is driven.

## Operation
- **States:** IDLE → LOAD_W → CLR → FETCH → COMPUTE → (DRAIN) → … → DONE → IDLE.
- **IDLE**
  - `start`=1 latches the configuration and moves to LOAD_W.
  - `start` while not in IDLE is ignored.
- **LOAD_W (pipelined)**
  - Cycle i (i < N_ROWS): `mem_rd`=1, `mem_addr`=`w_base`+4i.
  - Cycle i+1: `write`=1, `address`=i, `input_data`=`mem_rdata`.
  - Takes N_ROWS+1 cycles.
- **CLR**
  - One cycle with `reset_output`=1.
  - If `n_vec`=0, go straight to DONE with no RAM writes.
- **FETCH v**
  - `mem_rd`=1, `mem_addr`=`x_base`+4v.
- **COMPUTE v**
  - `cim`=1, `input_data`=`mem_rdata`, `partial_sum`=`accumulate`.
- **DRAIN (pipelined)**
  - Cycle k (k < N_OUT): `output_reg`=k.
  - Cycle k+1: `mem_wr`=1, `mem_wdata`=`cim_output`, `mem_addr`=`y_base`+4(b·N_OUT+k).
  - b = v when `accumulate`=0; b = 0 when `accumulate`=1.
  - Takes N_OUT+1 cycles.
- **Sequencing by mode**
  - `accumulate`=0: DRAIN follows every COMPUTE.
  - `accumulate`=1: COMPUTE v goes directly to FETCH v+1; one DRAIN follows only the last COMPUTE.
- **DONE**
  - One cycle: `done`=1, `busy`=0, then IDLE.
- **Exclusivity**
  - `mem_rd` and `mem_wr` are never high in the same cycle.
  - At most one of `write`, `cim`, `reset_output` is high per cycle.
- **Arithmetic:** address arithmetic is 32-bit modulo; wrap-around is silent.

## Timing
- **Reset values:** every output is 0 and the state is IDLE.
  - Asserting `RESN` mid-job aborts immediately.
  - No `done` is produced and no further RAM or CIM strobes follow.
- **`busy`:** rises the cycle after `start` is accepted and falls in the DONE cycle.
- **Strobes:** every strobe is a single-cycle pulse. Address/data are valid in the same cycle as their strobe.
- **Busy cycles, `accumulate`=0:** (N_ROWS+1) + 1 + n_vec·(N_OUT+3).
- **Busy cycles, `accumulate`=1:** (N_ROWS+1) + 1 + 2·n_vec + (N_OUT+1).
- **Busy cycles, `n_vec`=0:** N_ROWS+2.
- **Defaults check:** `accumulate`=0 with n_vec=2 → 72 cycles; `accumulate`=1 with n_vec=3 → 57 cycles.

## Test plan
- **Weight load:** `w_base`=0x100, `n_vec`=0 with a RAM pattern word i = 0xA000_0000+i.
  - Expect 32 `write` pulses with `address`=i and matching data.
  - Expect `busy` for 34 cycles, then one `done`, and zero `mem_wr`.
- **Per-vector drain:** `accumulate`=0, `n_vec`=2, `x_base`=0x200, `y_base`=43776, with a behavioural CIM model.
  - Expect 32 writes to 43776..43900 matching the model.
  - Expect `partial_sum`=0 on both `cim` pulses and `busy` for 72 cycles.
- **Accumulate:** `accumulate`=1, `n_vec`=3.
  - Expect 3 `cim` pulses with `partial_sum`=1, exactly 16 writes at `y_base`..`y_base`+60, and `busy` for 57 cycles.
- **Restart ignored:** pulse `start` again mid-LOAD_W.
  - Expect the configuration unchanged, the same trace as the single-start run, and exactly one `done`.
- **Reset abort:** assert `RESN` low during DRAIN k=5.
  - Expect all outputs 0 within the same cycle, no `done`, and that a new `start` afterwards completes normally.
- **Wrap:** `y_base`=0xFFFF_FFF8 with `accumulate`=1.
  - Expect write addresses 0xFFFF_FFF8, 0xFFFF_FFFC, then 0x0, 0x4, …
